// File: rtl/axi_xbar_aw_arbiter.sv
// axi_xbar_aw_arbiter: round-robin AW arbiter with W-routing FIFO for one crossbar master port (clk_i/rst_i, slv_* requesters, mst_* master AW, w_* routing)
module axi_xbar_aw_arbiter #(
  parameter int unsigned NoSlvPorts = 4,
  parameter int unsigned PayloadWidth = 64,
  parameter int unsigned MaxWTrans = 8,
  localparam int unsigned IdxWidth = NoSlvPorts == 1 ? 1 : $clog2(NoSlvPorts)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NoSlvPorts-1:0]              slv_valid_i,
  output logic [NoSlvPorts-1:0]              slv_ready_o,
  input  logic [NoSlvPorts*PayloadWidth-1:0] slv_payload_i,
  output logic                               mst_valid_o,
  input  logic                               mst_ready_i,
  output logic [PayloadWidth-1:0]            mst_payload_o,
  output logic [IdxWidth-1:0]                mst_idx_o,
  output logic                               w_sel_valid_o,
  output logic [IdxWidth-1:0]                w_sel_o,
  input  logic                               w_last_done_i,
  output logic                               w_fifo_full_o
);
  localparam int unsigned PtrWidth = MaxWTrans == 1 ? 1 : $clog2(MaxWTrans);
  localparam int unsigned CntWidth = $clog2(MaxWTrans + 1);
  typedef enum logic {IDLE, LOCKED} state_e;
  state_e state;
  logic [IdxWidth-1:0] ptr, lock_idx, arb_idx, cand, grant_idx;
  logic arb_found, full, grant, hs, pop;
  logic [IdxWidth-1:0] fifo_mem [MaxWTrans];
  logic [PtrWidth-1:0] wr_ptr, rd_ptr;
  logic [CntWidth-1:0] count;
  always_comb begin
    arb_found = 1'b0;
    arb_idx = '0;
    cand = '0;
    for (int k = 0; k < int'(NoSlvPorts); k++) begin
      cand = IdxWidth'((int'(ptr) + k) % int'(NoSlvPorts));
      if (!arb_found && slv_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_idx = cand;
      end
    end
  end
  // A full FIFO blocks new grants; a lock was only taken with a free slot, so it is never blocked.
  assign full = count == CntWidth'(MaxWTrans);
  assign grant = state == LOCKED || (arb_found && !full);
  assign grant_idx = state == LOCKED ? lock_idx : arb_idx;
  assign hs = grant && mst_ready_i && !rst_i;
  assign pop = w_last_done_i && count != '0 && !rst_i;
  assign mst_valid_o = grant && !rst_i;
  assign mst_idx_o = mst_valid_o ? grant_idx : '0;
  assign mst_payload_o = mst_valid_o ? slv_payload_i[grant_idx*PayloadWidth +: PayloadWidth] : '0;
  assign slv_ready_o = hs ? NoSlvPorts'(1) << grant_idx : '0;
  assign w_sel_valid_o = !rst_i && count != '0;
  assign w_sel_o = w_sel_valid_o ? fifo_mem[rd_ptr] : '0;
  assign w_fifo_full_o = full && !rst_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr <= '0;
      lock_idx <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (state == IDLE && grant && !mst_ready_i) begin
        state <= LOCKED;
        lock_idx <= arb_idx;
      end else if (state == LOCKED && mst_ready_i) begin
        state <= IDLE;
      end
      if (hs) begin
        ptr <= grant_idx == IdxWidth'(NoSlvPorts - 1) ? '0 : grant_idx + 1'b1;
        fifo_mem[wr_ptr] <= grant_idx;
        wr_ptr <= wr_ptr == PtrWidth'(MaxWTrans - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr == PtrWidth'(MaxWTrans - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CntWidth'(hs) - CntWidth'(pop);
    end
  end
`ifndef SYNTHESIS
  logic stall_q;
  logic [IdxWidth-1:0] idx_q;
  logic [PayloadWidth-1:0] pay_q;
  always_ff @(posedge clk_i) begin
    stall_q <= mst_valid_o && !mst_ready_i;
    idx_q <= mst_idx_o;
    pay_q <= mst_payload_o;
    if (!rst_i) begin
      assert ($onehot0(slv_ready_o));
      assert (!stall_q || (mst_idx_o == idx_q && mst_payload_o == pay_q));
      assert (!pop || count != '0);
    end
  end
`endif
endmodule
